// File: rtl/tipos_pkg.sv
// Shared types and constants for the setup menu: password/BCD packs,
// the configuration record, special key codes and reset defaults.
package tipos_pkg;

  localparam int MAX_USERS    = 5;
  localparam int SENHA_DIGITS = 20;
  localparam int IDX_W        = 3;

  // digits[0] is the most recent key; unused positions hold 4'hF
  typedef logic [SENHA_DIGITS-1:0][3:0] senhaPac_t;
  // BCD0..BCD5 of the front-panel display
  typedef logic [5:0][3:0] bcdPac_t;

  typedef struct packed {
    logic                        bip_status;
    logic [6:0]                  bip_time;
    logic [6:0]                  tranca_aut_time;
    senhaPac_t                   senha_master;
    senhaPac_t [MAX_USERS-1:0]   senha_user;
  } setupPacN_t;

  typedef enum logic [2:0] {
    IDLE, BIP_EN, BIP_TIME, TRC_TIME, PW, SAVE, ABORT
  } menu_state_t;

  // Whole-entry special codes (every nibble equal)
  localparam senhaPac_t SENHA_CANCEL = {SENHA_DIGITS{4'hC}};
  localparam senhaPac_t SENHA_BACK   = {SENHA_DIGITS{4'hA}};
  localparam senhaPac_t SENHA_SAVE   = {SENHA_DIGITS{4'hB}};
  localparam senhaPac_t SENHA_ALL_F  = {SENHA_DIGITS{4'hF}};
  localparam senhaPac_t SENHA_IGNORE = {SENHA_DIGITS{4'hE}};

  localparam bcdPac_t   BCD_BLANK        = {6{4'hB}};
  localparam senhaPac_t SENHA_MASTER_DEF = {{16{4'hF}}, 16'h1234};

  localparam setupPacN_t SETUP_DEFAULT = {1'b1, 7'd5, 7'd5, SENHA_MASTER_DEF,
                                          {MAX_USERS{SENHA_ALL_F}}};

  // Keep the first n digits of a password, blank the rest with 4'hF
  function automatic senhaPac_t pw_trim(senhaPac_t d, int n);
    senhaPac_t r;
    for (int i = 0; i < SENHA_DIGITS; i++) begin
      r[i] = (i < n) ? d[i] : 4'hF;
    end
    return r;
  endfunction

endpackage

// File: rtl/setup_menu_param_if.sv
// Keypad-entry / configuration-output bundle of the setup menu.
// Handshake: digitos_valid is a one-cycle strobe qualifying digitos_value;
// there is no ready -- any entry strobed while the menu is in BIP_EN..PW is
// consumed on that edge, entries in IDLE/SAVE/ABORT are dropped.
interface setup_menu_param_if;
  import tipos_pkg::*;

  logic       setup_on;
  senhaPac_t  digitos_value;
  logic       digitos_valid;
  logic       display_en;
  bcdPac_t    bcd_pac;
  setupPacN_t data_setup_new;
  logic       data_setup_ok;
  logic       data_setup_abort;
  logic       entry_err;

  modport master (
    output setup_on, digitos_value, digitos_valid,
    input  display_en, bcd_pac, data_setup_new,
           data_setup_ok, data_setup_abort, entry_err
  );

  modport slave (
    input  setup_on, digitos_value, digitos_valid,
    output display_en, bcd_pac, data_setup_new,
           data_setup_ok, data_setup_abort, entry_err
  );
endinterface

// File: rtl/setup_time_parse.sv
// Combinational decode of a one- or two-digit seconds entry, clamped to
// [T_MIN, T_MAX]; o_err flags a non-decimal nibble among the used digits.
module setup_time_parse
  import tipos_pkg::*;
#(
  parameter int T_MIN = 5,
  parameter int T_MAX = 60
) (
  input  senhaPac_t  i_digits,
  output logic [6:0] o_value,
  output logic       o_err
);

  logic [3:0] w_d0;
  logic [3:0] w_d1;
  logic [6:0] w_raw;

  assign w_d0 = i_digits[0];
  assign w_d1 = i_digits[1];

  // Decode the digits and clamp the result into the legal window
  always_comb begin
    if (w_d1 == 4'hF) begin
      w_raw = {3'b000, w_d0};
      o_err = (w_d0 > 4'd9);
    end else begin
      w_raw = 7'(w_d1) * 7'd10 + 7'(w_d0);
      o_err = (w_d1 > 4'd9) || (w_d0 > 4'd9);
    end
    if (w_raw < 7'(T_MIN))      o_value = 7'(T_MIN);
    else if (w_raw > 7'(T_MAX)) o_value = 7'(T_MAX);
    else                        o_value = w_raw;
  end

endmodule

// File: rtl/setup_menu_param.sv
// Setup menu: walks the user through buzzer enable, two time fields and the
// master/user passwords, editing a working copy that is committed on SAVE.
module setup_menu_param
  import tipos_pkg::*;
#(
  parameter int NUM_USERS   = 4,
  parameter int PW_MIN      = 4,
  parameter int PW_MAX      = 12,
  parameter int T_MIN       = 5,
  parameter int T_MAX       = 60,
  parameter int TIMEOUT_CYC = 30000
) (
  input  logic              clk,
  input  logic              rst,
  setup_menu_param_if.slave menu,
  output menu_state_t       o_dbg_state,
  output logic [IDX_W-1:0]  o_dbg_idx
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_USERS);

  menu_state_t      r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  menu_state_t      w_adv_state, w_prev_state;
  logic [IDX_W-1:0] w_adv_idx, w_prev_idx, w_uidx;
  setupPacN_t       r_committed, r_working;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  senhaPac_t        r_last;
  bcdPac_t          w_bcd;

  logic       w_active, w_entry, w_special, w_accept;
  logic       w_cancel, w_back, w_save, w_skip, w_ignore;
  logic       w_pw_ok, w_pw_cap_ok;
  logic [6:0] w_time_val;
  logic       w_time_err;

  assign w_active  = (r_state == BIP_EN) || (r_state == BIP_TIME) ||
                     (r_state == TRC_TIME) || (r_state == PW);
  assign w_entry   = w_active && menu.digitos_valid;
  assign w_cancel  = (menu.digitos_value == SENHA_CANCEL);
  assign w_back    = (menu.digitos_value == SENHA_BACK);
  assign w_save    = (menu.digitos_value == SENHA_SAVE);
  assign w_skip    = (menu.digitos_value == SENHA_ALL_F);
  assign w_ignore  = (menu.digitos_value == SENHA_IGNORE);
  assign w_special = w_cancel || w_back || w_save || w_skip || w_ignore;
  assign w_uidx    = r_idx - 1'b1;

  // A full 20-digit limit leaves no nibble to check for overflow
  if (PW_MAX < SENHA_DIGITS) begin : g_pw_cap
    assign w_pw_cap_ok = (menu.digitos_value[PW_MAX] == 4'hF);
  end else begin : g_pw_nocap
    assign w_pw_cap_ok = 1'b1;
  end
  assign w_pw_ok = (menu.digitos_value[PW_MIN-1] != 4'hF) && w_pw_cap_ok;

  setup_time_parse #(.T_MIN(T_MIN), .T_MAX(T_MAX)) u_time_parse (
    .i_digits (menu.digitos_value),
    .o_value  (w_time_val),
    .o_err    (w_time_err)
  );

  // Field-level acceptance of a non-special entry in the current step
  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      BIP_EN:             w_accept = (menu.digitos_value[0] <= 4'd1);
      BIP_TIME, TRC_TIME: w_accept = !w_time_err;
      PW:                 w_accept = w_pw_ok;
      default:            w_accept = 1'b0;
    endcase
  end

  // State register: menu step and password index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next-state: neighbours of the current step, then entry/timeout decision
  always_comb begin
    w_adv_state  = r_state;
    w_adv_idx    = r_idx;
    w_prev_state = r_state;
    w_prev_idx   = r_idx;
    case (r_state)
      BIP_EN:   w_adv_state = BIP_TIME;
      BIP_TIME: begin w_adv_state = TRC_TIME; w_prev_state = BIP_EN; end
      TRC_TIME: begin w_adv_state = PW; w_adv_idx = '0; w_prev_state = BIP_TIME; end
      PW: begin
        if (r_idx == IDX_LAST) w_adv_state = SAVE;
        else                   w_adv_idx   = r_idx + 1'b1;
        if (r_idx == '0)       w_prev_state = TRC_TIME;
        else                   w_prev_idx   = r_idx - 1'b1;
      end
      default: ;
    endcase

    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      IDLE: if (menu.setup_on) begin
        w_state_next = BIP_EN;
        w_idx_next   = '0;
      end
      SAVE, ABORT: w_state_next = IDLE;
      default: begin
        if (menu.digitos_valid) begin
          if (w_cancel) begin
            w_state_next = ABORT;
          end else if (w_back) begin
            w_state_next = w_prev_state;
            w_idx_next   = w_prev_idx;
          end else if (w_save) begin
            w_state_next = SAVE;
          end else if (w_skip || (!w_ignore && w_accept)) begin
            w_state_next = w_adv_state;
            w_idx_next   = w_adv_idx;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = ABORT;
        end
      end
    endcase
  end

  // Output decode: step number and echoed digits; passwords never shown
  always_comb begin
    w_bcd = BCD_BLANK;
    case (r_state)
      BIP_EN:   begin w_bcd[5] = 4'd1; w_bcd[0] = r_last[0]; end
      BIP_TIME: begin w_bcd[5] = 4'd2; w_bcd[1] = r_last[1]; w_bcd[0] = r_last[0]; end
      TRC_TIME: begin w_bcd[5] = 4'd3; w_bcd[1] = r_last[1]; w_bcd[0] = r_last[0]; end
      PW:       w_bcd[5] = 4'd4 + {1'b0, r_idx};
      default: ;
    endcase
  end

  assign menu.bcd_pac          = w_bcd;
  assign menu.display_en       = (r_state != IDLE);
  assign menu.data_setup_ok    = (r_state == SAVE);
  assign menu.data_setup_abort = (r_state == ABORT);
  assign menu.entry_err        = r_err;
  assign menu.data_setup_new   = r_committed;
  assign o_dbg_state           = r_state;
  assign o_dbg_idx             = r_idx;

  // Datapath: working/committed copies, inactivity counter, echo and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_working   <= SETUP_DEFAULT;
      r_committed <= SETUP_DEFAULT;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_last      <= SENHA_ALL_F;
    end else begin
      r_err <= w_entry && !w_special && !w_accept;
      if (r_state == IDLE) begin
        r_cnt <= '0;
        if (menu.setup_on) begin
          r_working <= r_committed;
          r_last    <= SENHA_ALL_F;
        end
      end else if (w_active) begin
        if (menu.digitos_valid) begin
          r_cnt  <= '0;
          r_last <= menu.digitos_value;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_entry && !w_special && w_accept) begin
          case (r_state)
            BIP_EN:   r_working.bip_status      <= menu.digitos_value[0][0];
            BIP_TIME: r_working.bip_time        <= w_time_val;
            TRC_TIME: r_working.tranca_aut_time <= w_time_val;
            PW: begin
              if (r_idx == '0) r_working.senha_master       <= pw_trim(menu.digitos_value, PW_MAX);
              else             r_working.senha_user[w_uidx] <= pw_trim(menu.digitos_value, PW_MAX);
            end
            default: ;
          endcase
        end
      end else begin
        r_cnt <= '0;
        if (r_state == SAVE) r_committed <= r_working;
      end
    end
  end

endmodule

// File: tb/tb_setup_menu_param.sv
// Bench for setup_menu_param: directed menu walks plus randomized sessions,
// every cycle compared against a step-number reference model.
module tb_setup_menu_param;
  import tipos_pkg::*;

  localparam int NUM_USERS = 4;
  localparam int PW_MIN    = 4;
  localparam int PW_MAX    = 12;
  localparam int T_MIN     = 5;
  localparam int T_MAX     = 60;
  localparam int TIMEOUT   = 100;
  localparam int LAST_STEP = 4 + NUM_USERS;
  localparam senhaPac_t ALL_F = {20{4'hF}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  setup_menu_param_if u_if();
  menu_state_t        dbg_state;
  logic [IDX_W-1:0]   dbg_idx;

  setup_menu_param #(
    .NUM_USERS(NUM_USERS), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX),
    .T_MIN(T_MIN), .T_MAX(T_MAX), .TIMEOUT_CYC(TIMEOUT)
  ) u_dut (
    .clk(clk), .rst(rst), .menu(u_if),
    .o_dbg_state(dbg_state), .o_dbg_idx(dbg_idx)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int ok_seen = 0;
  int abort_seen = 0;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 in menu at step m_step (1..LAST_STEP), 2 save, 3 abort
  int         m_phase, m_step, m_cnt;
  setupPacN_t m_work, m_comm, def_cfg;
  senhaPac_t  m_last;
  logic       m_err;

  function automatic logic all_of(senhaPac_t d, logic [3:0] n);
    for (int i = 0; i < 20; i++) if (d[i] != n) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    def_cfg.bip_status      = 1'b1;
    def_cfg.bip_time        = 7'd5;
    def_cfg.tranca_aut_time = 7'd5;
    def_cfg.senha_master    = {{16{4'hF}}, 4'd1, 4'd2, 4'd3, 4'd4};
    for (int u = 0; u < MAX_USERS; u++) def_cfg.senha_user[u] = ALL_F;
    m_work = def_cfg; m_comm = def_cfg;
    m_phase = 0; m_step = 1; m_cnt = 0; m_err = 1'b0; m_last = ALL_F;
  endtask

  task automatic model_next();
    m_step++;
    if (m_step > LAST_STEP) m_phase = 2;
  endtask

  task automatic model_update(input logic son, input logic val, input senhaPac_t d);
    int v;
    bit bad;
    senhaPac_t p;
    m_err = 1'b0;
    case (m_phase)
      0: if (son) begin m_work = m_comm; m_phase = 1; m_step = 1; m_cnt = 0; m_last = ALL_F; end
      2: begin m_comm = m_work; m_phase = 0; end
      3: m_phase = 0;
      default: begin
        if (val) begin
          m_cnt = 0; m_last = d;
          if (all_of(d, 4'hC)) m_phase = 3;
          else if (all_of(d, 4'hA)) begin if (m_step > 1) m_step--; end
          else if (all_of(d, 4'hB)) m_phase = 2;
          else if (all_of(d, 4'hF)) model_next();
          else if (all_of(d, 4'hE)) ;
          else if (m_step == 1) begin
            if (d[0] <= 4'd1) begin m_work.bip_status = d[0][0]; model_next(); end
            else m_err = 1'b1;
          end else if (m_step <= 3) begin
            if (d[1] == 4'hF) begin bad = (d[0] > 9); v = int'(d[0]); end
            else begin bad = (d[1] > 9) || (d[0] > 9); v = int'(d[1]) * 10 + int'(d[0]); end
            if (bad) m_err = 1'b1;
            else begin
              if (v < T_MIN) v = T_MIN;
              if (v > T_MAX) v = T_MAX;
              if (m_step == 2) m_work.bip_time = 7'(v);
              else             m_work.tranca_aut_time = 7'(v);
              model_next();
            end
          end else begin
            if (d[PW_MIN-1] != 4'hF && d[PW_MAX] == 4'hF) begin
              p = ALL_F;
              for (int i = 0; i < PW_MAX; i++) p[i] = d[i];
              if (m_step == 4) m_work.senha_master = p;
              else             m_work.senha_user[m_step-5] = p;
              model_next();
            end else m_err = 1'b1;
          end
        end else begin
          m_cnt++;
          if (m_cnt == TIMEOUT - 1) m_phase = 3;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    bcdPac_t e;
    e = {6{4'hB}};
    if (m_phase == 1) begin
      e[5] = 4'(m_step);
      if (m_step == 1) e[0] = m_last[0];
      if (m_step == 2 || m_step == 3) begin e[1] = m_last[1]; e[0] = m_last[0]; end
    end
    chk("display_en", u_if.display_en, m_phase != 0);
    chk("bcd_pac", u_if.bcd_pac, e);
    chk("setup_ok", u_if.data_setup_ok, m_phase == 2);
    chk("setup_abort", u_if.data_setup_abort, m_phase == 3);
    chk("entry_err", u_if.entry_err, m_err);
    chk("data_setup_new", u_if.data_setup_new, m_comm);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic son, input logic val, input senhaPac_t d);
    u_if.setup_on = son; u_if.digitos_valid = val; u_if.digitos_value = d;
    @(posedge clk);
    model_update(son, val, d);
    @(negedge clk);
    compare_all();
    if (u_if.data_setup_ok) ok_seen++;
    if (u_if.data_setup_abort) abort_seen++;
  endtask

  task automatic key(input senhaPac_t d);
    cycle(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, ALL_F);
  endtask

  function automatic senhaPac_t num_entry(int val, int ndig);
    senhaPac_t d;
    int v;
    d = ALL_F; v = val;
    for (int i = 0; i < ndig; i++) begin d[i] = 4'(v % 10); v = v / 10; end
    return d;
  endfunction

  function automatic senhaPac_t gen_entry(int step);
    senhaPac_t d;
    int r, len;
    d = ALL_F;
    r = $urandom_range(0, 99);
    if (r < 3)       d = {20{4'hC}};
    else if (r < 10) d = {20{4'hA}};
    else if (r < 13) d = {20{4'hB}};
    else if (r < 22) d = {20{4'hF}};
    else if (r < 26) d = {20{4'hE}};
    else if (step == 1) d[0] = 4'($urandom_range(0, 3));
    else if (step <= 3) begin
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++)
        d[i] = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(10, 14)) : 4'($urandom_range(0, 9));
    end else begin
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) d[i] = 4'($urandom_range(0, 9));
    end
    return d;
  endfunction

  // Run bound in case the DUT or bench wedges
  initial begin
    #5ms;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    u_if.setup_on = 1'b0; u_if.digitos_valid = 1'b0; u_if.digitos_value = ALL_F;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_cfg", u_if.data_setup_new, def_cfg);
    rst = 1'b0;

    // enter 1, 07, 99, skip the five passwords
    ok_seen = 0;
    cycle(1'b1, 1'b0, ALL_F);
    key(num_entry(1, 1));
    key(num_entry(7, 2));
    key(num_entry(99, 2));
    repeat (5) key(ALL_F);
    idle(2);
    chk("req29_bip_time", u_if.data_setup_new.bip_time, 7);
    chk("req29_trc_time", u_if.data_setup_new.tranca_aut_time, 60);
    chk("req29_ok_count", ok_seen, 1);

    // bip 0 then cancel
    abort_seen = 0;
    cycle(1'b1, 1'b0, ALL_F);
    key(num_entry(0, 1));
    key({20{4'hC}});
    idle(1);
    chk("req30_abort_count", abort_seen, 1);
    chk("req30_bip_status", u_if.data_setup_new.bip_status, 1'b1);

    // short master password rejected, six digits accepted
    cycle(1'b1, 1'b0, ALL_F);
    repeat (3) key(ALL_F);
    chk("req31_step4", u_if.bcd_pac[5], 4'd4);
    key(num_entry(12, 2));
    chk("req31_short_err", u_if.entry_err, 1'b1);
    chk("req31_short_stay", u_if.bcd_pac[5], 4'd4);
    key(num_entry(987654, 6));
    chk("req31_step5", u_if.bcd_pac[5], 4'd5);
    key({20{4'hB}});
    idle(2);
    chk("req31_master", u_if.data_setup_new.senha_master, {{14{4'hF}}, 24'h987654});

    // back from BIP_TIME, then illegal bip value
    cycle(1'b1, 1'b0, ALL_F);
    key(ALL_F);
    chk("req32_step2", u_if.bcd_pac[5], 4'd2);
    key({20{4'hA}});
    chk("req32_back_step1", u_if.bcd_pac[5], 4'd1);
    key(num_entry(2, 1));
    chk("req32_bip_err", u_if.entry_err, 1'b1);
    chk("req32_bip_stay", u_if.bcd_pac[5], 4'd1);
    chk("req32_bcd0_echo", u_if.bcd_pac[0], 4'd2);
    key({20{4'hC}});
    idle(1);

    // inactivity timeout
    cycle(1'b1, 1'b0, ALL_F);
    k = -1;
    for (int i = 1; i <= 150; i++) begin
      cycle(1'b0, 1'b0, ALL_F);
      if (u_if.data_setup_abort) begin k = i; break; end
    end
    chk("req33_timeout_cycle", k, 99);
    idle(1);

    // asynchronous reset while editing user password idx 2
    cycle(1'b1, 1'b0, ALL_F);
    repeat (5) key(ALL_F);
    chk("req33_step6", u_if.bcd_pac[5], 4'd6);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_display_en", u_if.display_en, 1'b0);
    chk("rst_bcd", u_if.bcd_pac, {6{4'hB}});
    chk("rst_cfg", u_if.data_setup_new, def_cfg);
    chk("rst_pulses", {u_if.data_setup_ok, u_if.data_setup_abort, u_if.entry_err}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      cycle(1'b1, 1'b0, ALL_F);
      for (int a = 0; a < 60 && m_phase != 0; a++) begin
        int gap;
        gap = ($urandom_range(0, 24) == 0) ? 100 : $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) cycle(1'($urandom_range(0, 1)), 1'b0, ALL_F);
        cycle(1'($urandom_range(0, 1)), 1'b1, gen_entry(m_step));
      end
      idle(2);
      cycle(1'b0, 1'b1, gen_entry(1));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/setup_menu_param.md
SETUP_MENU_PARAM -- requirements
Module: setup_menu_param

Interface
REQ-001 SHALL have parameter NUM_USERS, default 4: user passwords besides master; legal 1..5.
REQ-002 SHALL have parameter PW_MIN, default 4: minimum password digits; legal 1..PW_MAX.
REQ-003 SHALL have parameter PW_MAX, default 12: maximum password digits; legal PW_MIN..20.
REQ-004 SHALL have parameters T_MIN, default 5, and T_MAX, default 60: clamp bounds (seconds) for both time fields.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 30000: idle cycles before abort; minimum 2.
REQ-006 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports setup_on  in  1  menu request, sampled in IDLE only; digitos_value  in  senhaPac_t  20 BCD nibbles, digits[0] = last key, unused = 4'hF; digitos_valid  in  1  one-cycle entry strobe.
REQ-009 SHALL have outputs display_en  1; bcd_pac  bcdPac_t; data_setup_new  setupPacN_t  committed configuration; data_setup_ok  1  commit pulse; data_setup_abort  1  discard pulse; entry_err  1  rejected-entry pulse.

Function
REQ-010 SHALL hold two copies of setupPacN_t: committed (drives data_setup_new) and working.
REQ-011 SHALL use states IDLE, BIP_EN, BIP_TIME, TRC_TIME, PW, SAVE, ABORT; PW steps through index idx 0 (master) .. NUM_USERS.
REQ-012 IDLE: setup_on=1 -> copy committed into working, go to BIP_EN next cycle.
REQ-013 Special entries, priority high->low: all-4'hC cancel -> ABORT; all-4'hA back -> previous step (BIP_EN stays); all-4'hB -> SAVE; all-4'hF skip -> next step, field unchanged; all-4'hE ignored.
REQ-014 BIP_EN: digits[0] in {0,1} -> bip_status := digits[0], next; else entry_err, stay.
REQ-015 BIP_TIME/TRC_TIME: value = digits[0] if digits[1]==F, else digits[1]*10+digits[0], 7-bit; any used nibble >9 -> entry_err, stay; else store clamp(value,T_MIN,T_MAX), next.
REQ-016 PW: accept iff digits[PW_MIN-1]!=F and digits[PW_MAX]==F (PW_MAX<20); store digits[PW_MAX-1:0], upper nibbles 4'hF; reject -> entry_err, stay.
REQ-017 Step order BIP_EN -> BIP_TIME -> TRC_TIME -> PW idx0..NUM_USERS -> SAVE; back from PW idx0 -> TRC_TIME.
REQ-018 SAVE: one cycle; working -> committed at exit edge; data_setup_ok=1 for that cycle; -> IDLE.
REQ-019 ABORT: one cycle; working discarded; data_setup_abort=1; -> IDLE.
REQ-020 Inactivity counter clears on entry to BIP_EN and on every digitos_valid; reaching TIMEOUT_CYC-1 in any menu state -> ABORT; timeout and simultaneous digitos_valid: entry wins.
REQ-021 digitos_valid in IDLE/SAVE/ABORT ignored; setup_on outside IDLE ignored.
REQ-022 display_en=0 in IDLE, 1 elsewhere; BCD5 = step number (1,2,3, 4+idx) in menu states, 4'hB otherwise.
REQ-023 BCD0 = digits[0] in BIP_EN; BCD1:BCD0 = digits[1:0] in time states; all other BCD digits 4'hB (passwords never shown).
REQ-024 All outputs registered-state-derived; entry accepted on valid cycle takes effect next edge, one-cycle latency.

Reset
REQ-025 rst SHALL force IDLE, counters 0, pulses 0, display_en 0, BCD all 4'hB, from any state mid-operation.
REQ-026 Both copies reset to: bip_status 1, bip_time 5, tranca_aut_time 5, master = "1234" (rest 4'hF), users all 4'hF.

Structure
REQ-027 senhaPac_t, bcdPac_t, setupPacN_t (user password array sized by package constant MAX_USERS=5), special-code constants, defaults SHALL live in shared package tipos_pkg.
REQ-028 Time parse/clamp SHALL be sub-module setup_time_parse (combinational), instanced once, shared by both time states.

Verification
REQ-029 setup_on; enter 1, 07, 99, then skip x5 -> bip_time 7, tranca_aut_time 60, data_setup_ok pulse once.
REQ-030 setup_on; bip 0; then all-C -> data_setup_abort pulse, data_setup_new.bip_status stays 1.
REQ-031 PW_MIN=4: master "12" -> entry_err, stay step 4; "987654" -> stored, step 5.
REQ-032 At BIP_TIME enter all-A -> BCD5=1; enter 2 in BIP_EN -> entry_err, stay.
REQ-033 TIMEOUT_CYC=100, no entries -> abort on cycle 99 after entry; rst during PW idx 2 -> defaults restored, IDLE.
